// File: rtl/adc_uart_framer_pkg.sv
// Shared encodings and character constants for the ADC-to-UART hex framer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adc_uart_framer_pkg;

  // Framer sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

  // ASCII building blocks.
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_0     = 8'h30;
  // 'A' - 10: adding a nibble value of 10..15 lands on 'A'..'F'.
  localparam logic [7:0] ASCII_A_OFS = 8'h37;

  // Number of hex characters needed to print a w-bit value.
  function automatic int hex_digits(input int w);
    return (w + 3) / 4;
  endfunction

endpackage

// File: rtl/adc_uart_framer_hex.sv
// Converts one 4-bit nibble into its uppercase ASCII hex character.
// Latency: purely combinational.
// Backpressure: none.
module hex_to_ascii
  import adc_uart_framer_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] ascii
);

  // Digits map onto '0'..'9', letters onto 'A'..'F'.
  always_comb begin
    ascii = ASCII_0;
    if (nib < 4'd10) begin
      ascii = ASCII_0 + {4'h0, nib};
    end else begin
      ascii = ASCII_A_OFS + {4'h0, nib};
    end
  end

endmodule

// File: rtl/adc_uart_framer.sv
// Formats one ADC sample as uppercase hex (+ optional CR LF) and feeds it bytewise to uart_tx.
// Latency: tx_start rises 1 clk after capture when uart_tx is ready; 2 clk overhead per byte.
// Backpressure: sample_ready low while a frame is in flight; rejected strobes counted (sat. 255).
module adc_uart_framer
  import adc_uart_framer_pkg::*;
#(
  parameter int DATA_W    = 12,
  parameter bit SEND_CRLF = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  output logic              sample_ready,
  input  logic              tx_ready,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              busy,
  output logic [7:0]        drop_count
);

  localparam int NIB   = hex_digits(DATA_W);
  localparam int SW    = 4 * NIB;
  localparam int PAD   = SW - DATA_W;
  localparam int NCHAR = NIB + (SEND_CRLF ? 2 : 0);
  localparam int IDX_W = $clog2(NCHAR + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHAR - 1);
  localparam logic [IDX_W-1:0] CR_IDX   = IDX_W'(NIB);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] char_idx_q, char_idx_d;
  logic [SW-1:0]    shreg_q, shreg_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [7:0]       drop_count_q, drop_count_d;

  logic [SW-1:0]    aligned;
  logic [SW-1:0]    shifted;
  logic [IDX_W-1:0] char_next;
  logic [3:0]       nib_sel;
  logic [7:0]       hex_char;

  // Left-align the sample into whole nibbles (zero padding at the LSB end),
  // and precompute the shift register after consuming one digit.
  always_comb begin
    aligned   = SW'(sample_data) << PAD;
    shifted   = shreg_q << 4;
    char_next = char_idx_q + 1'b1;
    // In IDLE the first digit comes straight from the incoming sample so
    // tx_data is ready on entry to SEND; otherwise it is the next digit.
    nib_sel   = (state_q == ST_IDLE) ? aligned[SW-1 -: 4] : shifted[SW-1 -: 4];
  end

  hex_to_ascii u_hex (
    .nib   (nib_sel),
    .ascii (hex_char)
  );

  // Frame sequencer: next state, character index, shift register and byte.
  always_comb begin
    state_d    = state_q;
    char_idx_d = char_idx_q;
    shreg_d    = shreg_q;
    tx_data_d  = tx_data_q;
    case (state_q)
      ST_IDLE: begin
        if (sample_valid) begin
          shreg_d    = aligned;
          char_idx_d = '0;
          tx_data_d  = hex_char;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_ready) begin
          state_d = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        // uart_tx drops ready the cycle after start; do not trust the old ready.
        if (!tx_ready) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (tx_ready) begin
          if (char_idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
          end else begin
            char_idx_d = char_next;
            state_d    = ST_SEND;
            if (char_next < CR_IDX) begin
              shreg_d   = shifted;
              tx_data_d = hex_char;
            end else if (char_next == CR_IDX) begin
              tx_data_d = ASCII_CR;
            end else begin
              tx_data_d = ASCII_LF;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Count strobes that arrive while a frame is in flight, saturating at 255.
  always_comb begin
    drop_count_d = drop_count_q;
    if (sample_valid && (state_q != ST_IDLE) && (drop_count_q != 8'hFF)) begin
      drop_count_d = drop_count_q + 8'd1;
    end
  end

  // State registers; reset abandons any frame in progress.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      char_idx_q   <= '0;
      shreg_q      <= '0;
      tx_data_q    <= 8'h00;
      drop_count_q <= 8'h00;
    end else begin
      state_q      <= state_d;
      char_idx_q   <= char_idx_d;
      shreg_q      <= shreg_d;
      tx_data_q    <= tx_data_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Start is combinational from state and ready, giving exactly one pulse per byte.
  always_comb begin
    sample_ready = (state_q == ST_IDLE);
    busy         = (state_q != ST_IDLE);
    tx_start     = (state_q == ST_SEND) && tx_ready;
    tx_data      = tx_data_q;
    drop_count   = drop_count_q;
  end

endmodule

// File: tb/tb_adc_uart_framer.sv
module tb_adc_uart_framer;

  localparam int TX_CYC = 80;

  logic clk = 1'b0;
  always #42 clk = ~clk;

  logic        rstn;
  // Instance A: 12-bit, CR LF appended
  logic        sv_a;
  logic [11:0] sd_a;
  logic        srdy_a, st_a, busy_a, rdy_a;
  logic [7:0]  td_a, drop_a;
  // Instance B: 12-bit, digits only
  logic        sv_b;
  logic [11:0] sd_b;
  logic        srdy_b, st_b, busy_b, rdy_b;
  logic [7:0]  td_b, drop_b;

  int n_vec = 0;
  int n_err = 0;

  adc_uart_framer #(.DATA_W(12), .SEND_CRLF(1'b1)) dut_a (
    .clk(clk), .rstn(rstn), .sample_valid(sv_a), .sample_data(sd_a),
    .sample_ready(srdy_a), .tx_ready(rdy_a), .tx_start(st_a), .tx_data(td_a),
    .busy(busy_a), .drop_count(drop_a)
  );

  adc_uart_framer #(.DATA_W(12), .SEND_CRLF(1'b0)) dut_b (
    .clk(clk), .rstn(rstn), .sample_valid(sv_b), .sample_data(sd_b),
    .sample_ready(srdy_b), .tx_ready(rdy_b), .tx_start(st_b), .tx_data(td_b),
    .busy(busy_b), .drop_count(drop_b)
  );

  // uart_tx stand-ins: ready drops on the start edge and returns TX_CYC cycles later.
  int cnt_a, cnt_b;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdy_a <= 1'b1; cnt_a <= 0;
    end else if (rdy_a && st_a) begin
      rdy_a <= 1'b0; cnt_a <= TX_CYC;
    end else if (!rdy_a) begin
      if (cnt_a <= 1) rdy_a <= 1'b1;
      cnt_a <= cnt_a - 1;
    end
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdy_b <= 1'b1; cnt_b <= 0;
    end else if (rdy_b && st_b) begin
      rdy_b <= 1'b0; cnt_b <= TX_CYC;
    end else if (!rdy_b) begin
      if (cnt_b <= 1) rdy_b <= 1'b1;
      cnt_b <= cnt_b - 1;
    end
  end

  // Byte monitors: a start seen at the falling edge is consumed at the next rising edge.
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  int nst_b = 0, run_b = 0, maxrun_b = 0;
  always @(negedge clk) begin
    if (st_a) q_a.push_back(td_a);
    if (st_b) begin
      q_b.push_back(td_b);
      nst_b = nst_b + 1;
      run_b = run_b + 1;
      if (run_b > maxrun_b) maxrun_b = run_b;
    end else begin
      run_b = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    assert (obs === exp)
    else begin
      n_err = n_err + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_a(input logic [11:0] d);
    sd_a = d; sv_a = 1'b1;
    @(negedge clk);
    sv_a = 1'b0;
  endtask

  task automatic wait_idle_a(input string tag);
    for (int i = 0; i < 3000 && busy_a; i++) @(negedge clk);
    chk({tag, "_idle"}, 32'(busy_a), 32'd0);
    chk({tag, "_uart_done"}, 32'(rdy_a), 32'd1);
  endtask

  task automatic frame_a(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4);
    chk({tag, "_len"}, 32'(q_a.size()), 32'd5);
    chk({tag, "_b0"}, 32'(q_a.size() > 0 ? q_a[0] : 8'hxx), 32'(e0));
    chk({tag, "_b1"}, 32'(q_a.size() > 1 ? q_a[1] : 8'hxx), 32'(e1));
    chk({tag, "_b2"}, 32'(q_a.size() > 2 ? q_a[2] : 8'hxx), 32'(e2));
    chk({tag, "_b3"}, 32'(q_a.size() > 3 ? q_a[3] : 8'hxx), 32'(e3));
    chk({tag, "_b4"}, 32'(q_a.size() > 4 ? q_a[4] : 8'hxx), 32'(e4));
  endtask

  initial begin
    rstn = 1'b0;
    sv_a = 1'b0; sd_a = 12'h000;
    sv_b = 1'b0; sd_b = 12'h000;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_srdy", 32'(srdy_a), 32'd1);
    chk("rst_start", 32'(st_a), 32'd0);
    chk("rst_txdata", 32'(td_a), 32'h00);
    chk("rst_drop", 32'(drop_a), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // 1: 0xA5C with CR LF
    q_a.delete();
    send_a(12'hA5C);
    chk("t1_start_lat", 32'(st_a), 32'd1);
    chk("t1_busy", 32'(busy_a), 32'd1);
    chk("t1_srdy", 32'(srdy_a), 32'd0);
    wait_idle_a("t1");
    frame_a("t1", 8'h41, 8'h35, 8'h43, 8'h0D, 8'h0A);
    chk("t1_drop", 32'(drop_a), 32'd0);

    // 2: 0x000 on the digits-only instance
    q_b.delete(); nst_b = 0; maxrun_b = 0;
    sd_b = 12'h000; sv_b = 1'b1;
    @(negedge clk);
    sv_b = 1'b0;
    for (int i = 0; i < 3000 && busy_b; i++) @(negedge clk);
    chk("t2_idle", 32'(busy_b), 32'd0);
    chk("t2_len", 32'(q_b.size()), 32'd3);
    chk("t2_b0", 32'(q_b.size() > 0 ? q_b[0] : 8'hxx), 32'h30);
    chk("t2_b1", 32'(q_b.size() > 1 ? q_b[1] : 8'hxx), 32'h30);
    chk("t2_b2", 32'(q_b.size() > 2 ? q_b[2] : 8'hxx), 32'h30);
    chk("t2_nstart", 32'(nst_b), 32'd3);
    chk("t2_width", 32'(maxrun_b), 32'd1);

    // 3: second strobe 10 cycles after capture is dropped
    q_a.delete();
    send_a(12'h3C7);
    repeat (9) @(negedge clk);
    sd_a = 12'hFFF; sv_a = 1'b1;
    @(negedge clk);
    sv_a = 1'b0;
    chk("t3_drop", 32'(drop_a), 32'd1);
    wait_idle_a("t3");
    frame_a("t3", 8'h33, 8'h43, 8'h37, 8'h0D, 8'h0A);

    // 4: 300-cycle strobe while busy saturates the drop counter
    q_a.delete();
    send_a(12'h0B1);
    repeat (9) @(negedge clk);
    sd_a = 12'hEEE; sv_a = 1'b1;
    repeat (300) @(negedge clk);
    chk("t4_still_busy", 32'(busy_a), 32'd1);
    sv_a = 1'b0;
    chk("t4_drop_sat", 32'(drop_a), 32'hFF);
    wait_idle_a("t4");
    frame_a("t4", 8'h30, 8'h42, 8'h31, 8'h0D, 8'h0A);
    chk("t4_drop_hold", 32'(drop_a), 32'hFF);

    // 5: asynchronous reset mid-way through the second byte
    q_a.delete();
    send_a(12'h456);
    for (int i = 0; i < 3000 && q_a.size() < 2; i++) @(negedge clk);
    chk("t5_second_byte", 32'(q_a.size()), 32'd2);
    repeat (20) @(negedge clk);
    #10 rstn = 1'b0;
    #1;
    chk("t5_rst_start", 32'(st_a), 32'd0);
    chk("t5_rst_busy", 32'(busy_a), 32'd0);
    chk("t5_rst_drop", 32'(drop_a), 32'd0);
    chk("t5_rst_txdata", 32'(td_a), 32'h00);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    q_a.delete();
    send_a(12'hFFF);
    wait_idle_a("t5");
    frame_a("t5", 8'h46, 8'h46, 8'h46, 8'h0D, 8'h0A);

    // 6: strobe in the exact cycle the frame completes is dropped, next cycle accepted
    q_a.delete();
    send_a(12'h789);
    for (int i = 0; i < 3000 && !(busy_a && rdy_a && q_a.size() == 5); i++) @(negedge clk);
    chk("t6_at_exit", 32'(busy_a && rdy_a && q_a.size() == 5), 32'd1);
    chk("t6_exit_srdy", 32'(srdy_a), 32'd0);
    sd_a = 12'h999; sv_a = 1'b1;
    @(negedge clk);
    chk("t6_now_idle", 32'(busy_a), 32'd0);
    chk("t6_drop", 32'(drop_a), 32'd1);
    frame_a("t6a", 8'h37, 8'h38, 8'h39, 8'h0D, 8'h0A);
    q_a.delete();
    sd_a = 12'h123;
    @(negedge clk);
    sv_a = 1'b0;
    chk("t6_accepted", 32'(busy_a), 32'd1);
    wait_idle_a("t6");
    frame_a("t6b", 8'h31, 8'h32, 8'h33, 8'h0D, 8'h0A);
    chk("t6_drop_final", 32'(drop_a), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
